// File: rtl/ext_irq_ctrl.sv
// Machine-external interrupt controller: synchronizes, latches and masks NUM_SRC
// source lines, drives meip_o and exposes PENDING/ENABLE/TRIGGER/CLAIM registers.
module ext_irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               irq_ack_i,
  output logic               meip_o,
  input  logic [1:0]         addr_i,
  input  logic               wen_i,
  input  logic               ren_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o
);

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] ADDR_TRIGGER = 2'd2;
  localparam logic [1:0] ADDR_CLAIM   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic [31:0] zext(input logic [NUM_SRC-1:0] v);
    zext = {{(32-NUM_SRC){1'b0}}, v};
  endfunction

  logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] trigger_q, trigger_d;
  logic [31:0]        claim_q, claim_d;
  logic [31:0]        rdata_q, rdata_d;
  state_e             state_q;
  logic               meip_q;

  logic [NUM_SRC-1:0] act_s;
  logic [NUM_SRC-1:0] edge_s;
  logic [NUM_SRC-1:0] w1c_s;
  logic [NUM_SRC-1:0] sel_s;
  logic [NUM_SRC-1:0] clr_s;
  logic [4:0]         id_s;
  logic               take_s;
  logic               unused_s;

  assign unused_s = ^wdata_i[31:NUM_SRC];
  assign meip_o   = meip_q;
  assign rdata_o  = rdata_q;

  // Lowest-index active source; 0x1F when nothing is active at ack time.
  always_comb begin
    act_s  = pending_q & enable_q;
    edge_s = s2_q & ~s3_q;
    take_s = (state_q == ST_REQ) && irq_ack_i;
    id_s   = 5'h1F;
    sel_s  = {NUM_SRC{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (act_s[i]) begin
        id_s     = 5'(i);
        sel_s    = {NUM_SRC{1'b0}};
        sel_s[i] = 1'b1;
      end else begin
        sel_s = sel_s;
      end
    end
    if (wen_i && (addr_i == ADDR_PENDING)) begin
      w1c_s = wdata_i[NUM_SRC-1:0];
    end else begin
      w1c_s = {NUM_SRC{1'b0}};
    end
    clr_s = w1c_s | (take_s ? sel_s : {NUM_SRC{1'b0}});
  end

  // Pending bits: edge mode latches with set-over-clear, level mode follows s2.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (trigger_q[i]) begin
        pending_d[i] = edge_s[i] | (pending_q[i] & ~clr_s[i]);
      end else begin
        pending_d[i] = s2_q[i];
      end
    end
  end

  // Register writes, claim capture/clear and read-data mux.
  always_comb begin
    enable_d  = enable_q;
    trigger_d = trigger_q;
    claim_d   = claim_q;
    rdata_d   = rdata_q;
    if (wen_i && (addr_i == ADDR_ENABLE)) begin
      enable_d = wdata_i[NUM_SRC-1:0];
    end else begin
      enable_d = enable_q;
    end
    if (wen_i && (addr_i == ADDR_TRIGGER)) begin
      trigger_d = wdata_i[NUM_SRC-1:0];
    end else begin
      trigger_d = trigger_q;
    end
    if (take_s) begin
      claim_d = {1'b1, 26'd0, id_s};
    end else if (ren_i && (addr_i == ADDR_CLAIM)) begin
      claim_d = {1'b0, claim_q[30:0]};
    end else begin
      claim_d = claim_q;
    end
    if (ren_i) begin
      case (addr_i)
        ADDR_PENDING: rdata_d = zext(pending_q);
        ADDR_ENABLE:  rdata_d = zext(enable_q);
        ADDR_TRIGGER: rdata_d = zext(trigger_q);
        ADDR_CLAIM:   rdata_d = claim_q;
        default:      rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Synchronizer, edge-delay and register-file flops.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s1_q      <= {NUM_SRC{1'b0}};
      s2_q      <= {NUM_SRC{1'b0}};
      s3_q      <= {NUM_SRC{1'b0}};
      pending_q <= {NUM_SRC{1'b0}};
      enable_q  <= {NUM_SRC{1'b0}};
      trigger_q <= {NUM_SRC{1'b0}};
      claim_q   <= 32'd0;
      rdata_q   <= 32'd0;
    end else begin
      s1_q      <= src_i;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      trigger_q <= trigger_d;
      claim_q   <= claim_d;
      rdata_q   <= rdata_d;
    end
  end

  // Request handshake FSM; HOLD forces one low cycle after every ack.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      meip_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (act_s != {NUM_SRC{1'b0}}) begin
            state_q <= ST_REQ;
            meip_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            meip_q  <= 1'b0;
          end
        end
        ST_REQ: begin
          if (irq_ack_i) begin
            state_q <= ST_HOLD;
            meip_q  <= 1'b0;
          end else if (act_s == {NUM_SRC{1'b0}}) begin
            state_q <= ST_IDLE;
            meip_q  <= 1'b0;
          end else begin
            state_q <= ST_REQ;
            meip_q  <= 1'b1;
          end
        end
        ST_HOLD: begin
          state_q <= ST_IDLE;
          meip_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          meip_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed self-checking bench for ext_irq_ctrl; inputs change and outputs are
// sampled on the falling clock edge.
module tb_ext_irq_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [7:0]  src_i;
  logic        irq_ack_i;
  logic        meip_o;
  logic [1:0]  addr_i;
  logic        wen_i;
  logic        ren_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  int n_tests = 0;
  int n_fail  = 0;

  ext_irq_ctrl #(.NUM_SRC(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .src_i(src_i), .irq_ack_i(irq_ack_i),
    .meip_o(meip_o), .addr_i(addr_i), .wen_i(wen_i), .ren_i(ren_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr_i = a; wdata_i = d; wen_i = 1'b1;
    @(negedge clk_i);
    wen_i = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    addr_i = a; ren_i = 1'b1;
    @(negedge clk_i);
    ren_i = 1'b0;
    d = rdata_o;
  endtask

  task automatic ack_pulse();
    irq_ack_i = 1'b1;
    @(negedge clk_i);
    irq_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_i = 1'b0; src_i = 8'hFF; irq_ack_i = 1'b0;
    addr_i = 2'd0; wen_i = 1'b0; ren_i = 1'b0; wdata_i = 32'd0;
    repeat (3) @(negedge clk_i);
    n_tests++; if (meip_o !== 1'b0) begin n_fail++; $display("FAIL reset_meip: got %b expected 0", meip_o); end
    n_tests++; if (rdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata_o); end
    src_i = 8'h00; reset_i = 1'b1;
    @(negedge clk_i);
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 0", a, rd); end
    end
  endtask

  task automatic test_edge_single();
    logic [31:0] rd;
    bus_write(2'd2, 32'h04);
    bus_write(2'd1, 32'h04);
    src_i = 8'h04;
    @(negedge clk_i);
    src_i = 8'h00;
    @(negedge clk_i);
    @(negedge clk_i);
    n_tests++; if (meip_o !== 1'b0) begin n_fail++; $display("FAIL edge_early: got %b expected 0", meip_o); end
    @(negedge clk_i);
    n_tests++; if (meip_o !== 1'b1) begin n_fail++; $display("FAIL edge_latency: got %b expected 1", meip_o); end
    ack_pulse();
    n_tests++; if (meip_o !== 1'b0) begin n_fail++; $display("FAIL edge_ack_drop: got %b expected 0", meip_o); end
    bus_read(2'd3, rd);
    n_tests++; if (rd !== 32'h8000_0002) begin n_fail++; $display("FAIL edge_claim1: got %h expected 80000002", rd); end
    bus_read(2'd3, rd);
    n_tests++; if (rd !== 32'h0000_0002) begin n_fail++; $display("FAIL edge_claim2: got %h expected 00000002", rd); end
    bus_read(2'd0, rd);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL edge_pending: got %h expected 0", rd); end
  endtask

  task automatic test_priority();
    logic [31:0] rd;
    bus_write(2'd2, 32'hFF);
    bus_write(2'd1, 32'hFF);
    src_i = 8'h22;
    @(negedge clk_i);
    src_i = 8'h00;
    repeat (3) @(negedge clk_i);
    n_tests++; if (meip_o !== 1'b1) begin n_fail++; $display("FAIL prio_req: got %b expected 1", meip_o); end
    ack_pulse();
    n_tests++; if (meip_o !== 1'b0) begin n_fail++; $display("FAIL prio_hold: got %b expected 0", meip_o); end
    bus_read(2'd3, rd);
    n_tests++; if (rd !== 32'h8000_0001) begin n_fail++; $display("FAIL prio_claim1: got %h expected 80000001", rd); end
    n_tests++; if (meip_o !== 1'b0) begin n_fail++; $display("FAIL prio_idle: got %b expected 0", meip_o); end
    @(negedge clk_i);
    n_tests++; if (meip_o !== 1'b1) begin n_fail++; $display("FAIL prio_rearm: got %b expected 1", meip_o); end
    ack_pulse();
    bus_read(2'd3, rd);
    n_tests++; if (rd !== 32'h8000_0005) begin n_fail++; $display("FAIL prio_claim2: got %h expected 80000005", rd); end
    bus_read(2'd0, rd);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL prio_pending: got %h expected 0", rd); end
  endtask

  task automatic test_level_hold();
    logic [31:0] rd;
    bus_write(2'd2, 32'h00);
    bus_write(2'd1, 32'h01);
    src_i = 8'h01;
    repeat (4) @(negedge clk_i);
    n_tests++; if (meip_o !== 1'b1) begin n_fail++; $display("FAIL level_req: got %b expected 1", meip_o); end
    ack_pulse();
    n_tests++; if (meip_o !== 1'b0) begin n_fail++; $display("FAIL level_hold: got %b expected 0", meip_o); end
    @(negedge clk_i);
    @(negedge clk_i);
    n_tests++; if (meip_o !== 1'b1) begin n_fail++; $display("FAIL level_rearm: got %b expected 1", meip_o); end
    bus_read(2'd0, rd);
    n_tests++; if (rd !== 32'h01) begin n_fail++; $display("FAIL level_pending: got %h expected 01", rd); end
    bus_read(2'd3, rd);
    n_tests++; if (rd !== 32'h8000_0000) begin n_fail++; $display("FAIL level_claim: got %h expected 80000000", rd); end
    src_i = 8'h00;
    repeat (3) @(negedge clk_i);
    n_tests++; if (meip_o !== 1'b1) begin n_fail++; $display("FAIL level_still: got %b expected 1", meip_o); end
    @(negedge clk_i);
    n_tests++; if (meip_o !== 1'b0) begin n_fail++; $display("FAIL level_withdraw: got %b expected 0", meip_o); end
  endtask

  task automatic test_mask_w1c();
    logic [31:0] rd;
    bus_write(2'd1, 32'h00);
    bus_write(2'd2, 32'h08);
    src_i = 8'h08;
    @(negedge clk_i);
    src_i = 8'h00;
    repeat (4) @(negedge clk_i);
    n_tests++; if (meip_o !== 1'b0) begin n_fail++; $display("FAIL mask_quiet: got %b expected 0", meip_o); end
    bus_read(2'd0, rd);
    n_tests++; if (rd !== 32'h08) begin n_fail++; $display("FAIL mask_pending: got %h expected 08", rd); end
    bus_write(2'd1, 32'h08);
    @(negedge clk_i);
    n_tests++; if (meip_o !== 1'b1) begin n_fail++; $display("FAIL mask_enable: got %b expected 1", meip_o); end
    bus_write(2'd0, 32'h08);
    n_tests++; if (meip_o !== 1'b1) begin n_fail++; $display("FAIL w1c_same: got %b expected 1", meip_o); end
    @(negedge clk_i);
    n_tests++; if (meip_o !== 1'b0) begin n_fail++; $display("FAIL w1c_withdraw: got %b expected 0", meip_o); end
    bus_read(2'd0, rd);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL w1c_pending: got %h expected 0", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    src_i = 8'h08;
    @(negedge clk_i);
    src_i = 8'h00;
    @(negedge clk_i);
    @(negedge clk_i);
    src_i = 8'h08;
    @(negedge clk_i);
    src_i = 8'h00;
    n_tests++; if (meip_o !== 1'b1) begin n_fail++; $display("FAIL sim_req: got %b expected 1", meip_o); end
    @(negedge clk_i);
    ack_pulse();
    n_tests++; if (meip_o !== 1'b0) begin n_fail++; $display("FAIL sim_hold: got %b expected 0", meip_o); end
    bus_read(2'd3, rd);
    n_tests++; if (rd !== 32'h8000_0003) begin n_fail++; $display("FAIL sim_claim: got %h expected 80000003", rd); end
    bus_read(2'd0, rd);
    n_tests++; if (rd !== 32'h08) begin n_fail++; $display("FAIL sim_set_wins: got %h expected 08", rd); end
    n_tests++; if (meip_o !== 1'b1) begin n_fail++; $display("FAIL sim_rearm: got %b expected 1", meip_o); end
    addr_i = 2'd3; ren_i = 1'b1; irq_ack_i = 1'b1;
    @(negedge clk_i);
    ren_i = 1'b0; irq_ack_i = 1'b0;
    n_tests++; if (rdata_o !== 32'h0000_0003) begin n_fail++; $display("FAIL sim_read_old: got %h expected 00000003", rdata_o); end
    bus_read(2'd3, rd);
    n_tests++; if (rd !== 32'h8000_0003) begin n_fail++; $display("FAIL sim_capture_wins: got %h expected 80000003", rd); end
    bus_read(2'd0, rd);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL sim_pending_clr: got %h expected 0", rd); end
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rd);
    n_tests++; if (rd !== 32'h0000_0003) begin n_fail++; $display("FAIL claim_ro: got %h expected 00000003", rd); end
  endtask

  task automatic test_async_reset();
    bus_write(2'd2, 32'h00);
    bus_write(2'd1, 32'h01);
    src_i = 8'h01;
    repeat (4) @(negedge clk_i);
    n_tests++; if (meip_o !== 1'b1) begin n_fail++; $display("FAIL areset_req: got %b expected 1", meip_o); end
    #2 reset_i = 1'b0;
    #1;
    n_tests++; if (meip_o !== 1'b0) begin n_fail++; $display("FAIL areset_meip: got %b expected 0", meip_o); end
    n_tests++; if (rdata_o !== 32'd0) begin n_fail++; $display("FAIL areset_rdata: got %h expected 0", rdata_o); end
  endtask

  initial begin
    test_reset();
    test_edge_single();
    test_priority();
    test_level_hold();
    test_mask_w1c();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
